// File: rtl/detect_face_pkg.sv
// detect_face_pkg: shared defaults, classifier thresholds, sum widths and FSM states for detect_face
package detect_face_pkg;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 24;
  localparam int DEF_WIN = 8;
  localparam int DEF_NUM_LEVELS = 2;
  localparam int DEF_SUM_LO = 7400;
  localparam int DEF_SUM_HI = 7500;
  localparam int DEF_FEAT_THRESH = 1024;
  localparam int SUM_W = 16;
  localparam int DIFF_W = 17;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/vj_window_classifier.sv
// vj_window_classifier: combinational face test on one window (sum band plus bottom-minus-top feature)
module vj_window_classifier
  import detect_face_pkg::*;
#(
  parameter int WIN = DEF_WIN
) (
  input  logic [WIN-1:0][WIN-1:0][7:0] win,
  input  logic [SUM_W-1:0]             sum_lo,
  input  logic [SUM_W-1:0]             sum_hi,
  input  logic signed [DIFF_W-1:0]     feat_thresh,
  output logic                         face
);
  logic [SUM_W-1:0] s_top, s_bot, s;
  logic signed [DIFF_W-1:0] diff;
  always_comb begin
    s_top = '0;
    s_bot = '0;
    for (int i = 0; i < WIN; i++)
      for (int j = 0; j < WIN; j++)
        if (i < WIN / 2) s_top = s_top + SUM_W'(win[i][j]);
        else s_bot = s_bot + SUM_W'(win[i][j]);
    s = s_top + s_bot;
    diff = $signed({1'b0, s_bot}) - $signed({1'b0, s_top});
    face = (s >= sum_lo) && (s <= sum_hi) && (diff >= feat_thresh);
  end
endmodule

// File: rtl/detect_face.sv
// detect_face: two-level pyramid sliding-window face detector, one window per clock.
// Optional FACE_COUNT_EN adds a saturating per-frame face_count output.
module detect_face
  import detect_face_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int WIN = DEF_WIN,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int SUM_LO = DEF_SUM_LO,
  parameter int SUM_HI = DEF_SUM_HI,
  parameter int FEAT_THRESH = DEF_FEAT_THRESH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [IMG_H-1:0][IMG_W-1:0][7:0] laptop_img,
  input  logic                             laptop_img_rdy,
  output logic [1:0][31:0]                 face_coords,
  output logic                             face_coords_ready,
  output logic                             vj_pipeline_done,
  output logic [3:0]                       pyramid_number
`ifdef FACE_COUNT_EN
  ,
  output logic [15:0]                      face_count
`endif
);
  localparam int YW = $clog2(IMG_H);
  localparam int XW = $clog2(IMG_W);
  state_t state, state_d;
  logic [3:0] level, level_d;
  logic [15:0] row, row_d, col, col_d, row_max, col_max;
  logic load, scan, last_col, last_row, last_win, face;
  logic [IMG_H-1:0][IMG_W-1:0][7:0] frame;
  logic [WIN-1:0][WIN-1:0][7:0] win;
  assign scan = state == SCAN;
  assign row_max = 16'((IMG_H >> level) - WIN);
  assign col_max = 16'((IMG_W >> level) - WIN);
  assign last_col = col == col_max;
  assign last_row = row == row_max;
  assign last_win = last_col && last_row && (level == 4'(NUM_LEVELS - 1));
  // Level k pixel (y, x) is frame[y<<k][x<<k]; the window is gathered straight from the full frame.
  for (genvar i = 0; i < WIN; i++) begin : g_r
    for (genvar j = 0; j < WIN; j++) begin : g_c
      logic [YW-1:0] y;
      logic [XW-1:0] x;
      assign y = YW'((32'(row) + i) << level);
      assign x = XW'((32'(col) + j) << level);
      assign win[i][j] = frame[y][x];
    end
  end
  vj_window_classifier #(.WIN(WIN)) u_cls (
    .win(win),
    .sum_lo(SUM_W'(SUM_LO)),
    .sum_hi(SUM_W'(SUM_HI)),
    .feat_thresh(DIFF_W'(FEAT_THRESH)),
    .face(face)
  );
  always_comb begin
    state_d = state;
    level_d = level;
    row_d = row;
    col_d = col;
    load = 1'b0;
    if (!scan) begin
      load = laptop_img_rdy;
      state_d = laptop_img_rdy ? SCAN : IDLE;
      level_d = laptop_img_rdy ? '0 : level;
      row_d = laptop_img_rdy ? '0 : row;
      col_d = laptop_img_rdy ? '0 : col;
    end else begin
      col_d = last_col ? '0 : col + 16'd1;
      row_d = last_col ? (last_row ? '0 : row + 16'd1) : row;
      level_d = (last_col && last_row) ? level + 4'd1 : level;
      state_d = last_win ? IDLE : SCAN;
    end
  end
  always_ff @(posedge clock) if (load) frame <= laptop_img;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      level <= '0;
      row <= '0;
      col <= '0;
      face_coords <= '0;
      face_coords_ready <= 1'b0;
      vj_pipeline_done <= 1'b0;
      pyramid_number <= '0;
    end else begin
      state <= state_d;
      level <= level_d;
      row <= row_d;
      col <= col_d;
      face_coords_ready <= scan && face;
      vj_pipeline_done <= scan && last_win;
      if (scan && face) begin
        face_coords[0] <= 32'(row) << level;
        face_coords[1] <= 32'(col) << level;
        pyramid_number <= level;
      end
    end
  end
`ifdef FACE_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) face_count <= '0;
    else if (load) face_count <= '0;
    else if (scan && face && face_count != 16'hFFFF) face_count <= face_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_detect_face.sv
// tb_detect_face: randomized and directed frames checked cycle by cycle against a behavioural window model
module tb_detect_face;
  localparam int W = 32;
  localparam int H = 24;
  localparam int WN = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [H-1:0][W-1:0][7:0] laptop_img = '0;
  logic laptop_img_rdy = 1'b0;
  logic [1:0][31:0] face_coords;
  logic face_coords_ready, vj_pipeline_done;
  logic [3:0] pyramid_number;
`ifdef FACE_COUNT_EN
  logic [15:0] face_count;
`endif
  int img[H][W];
  bit e_face[$];
  int e_row[$], e_col[$], e_lvl[$];
  int hold_r = 0, hold_c = 0, hold_k = 0;
  int n_checks = 0, n_pass = 0;
  int first_m, n_seen, done_m;
  always #5 clock = ~clock;
  detect_face dut (
    .clock(clock),
    .reset(reset),
    .laptop_img(laptop_img),
    .laptop_img_rdy(laptop_img_rdy),
    .face_coords(face_coords),
    .face_coords_ready(face_coords_ready),
    .vj_pipeline_done(vj_pipeline_done),
    .pyramid_number(pyramid_number)
`ifdef FACE_COUNT_EN
    ,
    .face_count(face_count)
`endif
  );
  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic build_model(output int n_face);
    int st, sb, s, p;
    e_face.delete();
    e_row.delete();
    e_col.delete();
    e_lvl.delete();
    n_face = 0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r <= (H >> k) - WN; r++)
        for (int c = 0; c <= (W >> k) - WN; c++) begin
          st = 0;
          sb = 0;
          for (int i = 0; i < WN; i++)
            for (int j = 0; j < WN; j++) begin
              p = img[(r + i) << k][(c + j) << k];
              if (i < WN / 2) st += p;
              else sb += p;
            end
          s = st + sb;
          e_face.push_back(s >= 7400 && s <= 7500 && sb - st >= 1024);
          e_row.push_back(r << k);
          e_col.push_back(c << k);
          e_lvl.push_back(k);
          if (s >= 7400 && s <= 7500 && sb - st >= 1024) n_face++;
        end
  endtask
  task automatic clear_img();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 0;
  endtask
  task automatic fill(input int y0, input int y1, input int x0, input int x1, input int v);
    for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) img[y][x] = v;
  endtask
  task automatic check_cleared(input string tag);
    check({tag, "_ready"}, face_coords_ready, 0);
    check({tag, "_done"}, vj_pipeline_done, 0);
    check({tag, "_row"}, face_coords[0], 0);
    check({tag, "_col"}, face_coords[1], 0);
    check({tag, "_pyr"}, pyramid_number, 0);
`ifdef FACE_COUNT_EN
    check({tag, "_cnt"}, face_count, 0);
`endif
  endtask
  // Caller is at a negedge; rdy is raised for the coming edge (cycle T) and the scan is followed to T+nwin+1.
  task automatic run_frame(input int extra_at, input int abort_at);
    int nwin, nf, n;
    build_model(nf);
    nwin = e_face.size();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) laptop_img[y][x] = 8'(img[y][x]);
    laptop_img_rdy = 1'b1;
    first_m = -1;
    n_seen = 0;
    done_m = -1;
    for (int m = 1; m <= nwin + 1; m++) begin
      @(negedge clock);
      n = m - 2;
      if (n >= 0 && e_face[n]) begin
        hold_r = e_row[n];
        hold_c = e_col[n];
        hold_k = e_lvl[n];
      end
      check("ready", face_coords_ready, (n >= 0) ? e_face[n] : 1'b0);
      check("done", vj_pipeline_done, n == nwin - 1);
      check("row", face_coords[0], hold_r);
      check("col", face_coords[1], hold_c);
      check("pyr", pyramid_number, hold_k);
      if (face_coords_ready) begin
        n_seen++;
        if (first_m < 0) first_m = m;
      end
      if (vj_pipeline_done) done_m = m;
`ifdef FACE_COUNT_EN
      if (m == 1) check("cnt_clr", face_count, 0);
      if (n == nwin - 1) check("cnt_done", face_count, nf > 65535 ? 65535 : nf);
`endif
      laptop_img_rdy = (m == extra_at);
      if (m == extra_at)
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) laptop_img[y][x] = 8'($urandom);
      if (m == abort_at) begin
        reset = 1'b0;
        #1;
        check_cleared("abort");
        hold_r = 0;
        hold_c = 0;
        hold_k = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int q = 0; q < 300; q++) begin
          @(negedge clock);
          check("post_abort_done", vj_pipeline_done, 0);
          check("post_abort_ready", face_coords_ready, 0);
        end
        return;
      end
    end
  endtask
  task automatic rand_frame(input int t);
    int r, c, a, b;
    clear_img();
    if (t % 3 == 2) begin
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = $urandom_range(0, 255);
      return;
    end
    if (t % 2 == 1)
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = $urandom_range(0, 1);
    a = $urandom_range(16, 60);
    b = 232 + $urandom_range(0, 2) - a;
    if (t % 3 == 0) begin
      r = $urandom_range(0, 16);
      c = $urandom_range(0, 24);
      fill(r, r + 3, c, c + 7, a);
      fill(r + 4, r + 7, c, c + 7, b);
    end else begin
      r = $urandom_range(0, 4);
      c = $urandom_range(0, 8);
      fill(2 * r, 2 * r + 7, 2 * c, 2 * c + 15, a);
      fill(2 * r + 8, 2 * r + 15, 2 * c, 2 * c + 15, b);
    end
  endtask
  initial begin
    #2;
    check_cleared("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    clear_img();
    for (int q = 0; q < 5; q++) begin
      @(negedge clock);
      check_cleared("idle");
    end
    run_frame(0, 0);
    check("t1_faces", n_seen, 0);
    check("t1_done_cycle", done_m, 471);
    @(negedge clock);
    clear_img();
    fill(4, 7, 10, 17, 32);
    fill(8, 11, 10, 17, 200);
    run_frame(49, 0);
    check("t2_first_cycle", first_m, 112);
    check("t2_faces", n_seen, 1);
    check("t2_done_cycle", done_m, 471);
    clear_img();
    fill(8, 15, 16, 31, 32);
    fill(16, 23, 16, 31, 200);
    run_frame(0, 0);
    check("t3_first_cycle", first_m, 318);
    check("t3_faces", n_seen, 10);
    check("t3_last_pyr", pyramid_number, 1);
    @(negedge clock);
    run_frame(0, 200);
    @(negedge clock);
    run_frame(0, 0);
    check("t5_faces", n_seen, 10);
    check("t5_done_cycle", done_m, 471);
    for (int t = 0; t < 12; t++) begin
      rand_frame(t);
      @(negedge clock);
      run_frame(0, 0);
      check("rand_done_cycle", done_m, 471);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
